// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Run/pause/lap/clear sequencer for a cascaded decade-digit timer.
//   Divides i_clk into a one-cycle count tick for the least-significant digit,
//   issues a clear pulse to the digit chain and a latch pulse to the display
//   register, and turns the top digit's carry-out into a sticky overflow flag.
//
// Parameters
//   DIV            clk cycles per tick (>= 2); prescaler is $clog2(DIV) bits
//
// Ports
//   i_clk          system clock, all logic on posedge
//   i_rst          synchronous reset, active-high
//   i_btn_ss       start/stop button level (synchronised/debounced)
//   i_btn_lr       lap/reset button level (synchronised/debounced)
//   i_ovf_in       carry-out pulse of the most-significant digit
//   o_tick         count enable to the LS digit, 1-cycle pulse
//   o_cnt_clr      clear for the digit chain, 1-cycle pulse
//   o_lap_latch    capture strobe for the display register, 1-cycle pulse
//   o_display_hold display shows the latched value instead of live digits
//   o_ovf_flag     sticky overflow indicator
//   o_state        IDLE=0, RUN=1, PAUSE=2, LAP=3

module stopwatch_ctrl #(
  parameter int DIV = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_ss,
  input  logic       i_btn_lr,
  input  logic       i_ovf_in,
  output logic       o_tick,
  output logic       o_cnt_clr,
  output logic       o_lap_latch,
  output logic       o_display_hold,
  output logic       o_ovf_flag,
  output logic [1:0] o_state
);

  localparam int              PW        = $clog2(DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   w_presc_nxt;
  logic            r_tick;
  logic            w_tick_nxt;
  logic            r_cnt_clr;
  logic            w_cnt_clr_nxt;
  logic            r_lap_latch;
  logic            w_lap_nxt;
  logic            r_hold;
  logic            w_hold_nxt;
  logic            r_ovf;
  logic            w_ovf_nxt;
  logic            w_presc_clr;
  logic            r_ss_d;
  logic            r_lr_d;
  logic            w_ss_e;
  logic            w_lr_e;

  // Rising-edge detect; the delayed copies are forced high in reset so a
  // button held through reset does not register as a press.
  assign w_ss_e = i_btn_ss & ~r_ss_d;
  assign w_lr_e = i_btn_lr & ~r_lr_d;

  // Next-state and pulse decode; ovf_in outranks ss, which outranks lr.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_clr_nxt = 1'b0;
    w_lap_nxt     = 1'b0;
    w_hold_nxt    = r_hold;
    w_ovf_nxt     = r_ovf;
    w_presc_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_e) begin
          w_state_nxt = S_RUN;
        end else if (w_lr_e) begin
          w_cnt_clr_nxt = 1'b1;
          w_ovf_nxt     = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_ovf_in) begin
          w_state_nxt = S_PAUSE;
          w_ovf_nxt   = 1'b1;
        end else if (w_ss_e) begin
          w_state_nxt = S_PAUSE;
        end else if (w_lr_e) begin
          w_state_nxt = S_LAP;
          w_lap_nxt   = 1'b1;
          w_hold_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_LAP: begin
        if (i_ovf_in) begin
          w_state_nxt = S_PAUSE;
          w_ovf_nxt   = 1'b1;
          w_hold_nxt  = 1'b0;
        end else if (w_ss_e) begin
          w_state_nxt = S_PAUSE;
          w_hold_nxt  = 1'b0;
        end else if (w_lr_e) begin
          w_state_nxt = S_LAP;
          w_lap_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_LAP;
        end
      end
      S_PAUSE: begin
        if (w_ss_e) begin
          w_state_nxt = S_RUN;
        end else if (w_lr_e) begin
          w_state_nxt   = S_IDLE;
          w_cnt_clr_nxt = 1'b1;
          w_ovf_nxt     = 1'b0;
          w_presc_clr   = 1'b1;
        end else begin
          w_state_nxt = S_PAUSE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Prescaler: counts on the current state, so a transition in the same cycle
  // still advances it; frozen in PAUSE so a resume loses no fractional time.
  always_comb begin
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    if ((r_state == S_RUN) || (r_state == S_LAP)) begin
      if (r_presc == PRESC_MAX) begin
        w_presc_nxt = '0;
        w_tick_nxt  = 1'b1;
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end else if ((r_state == S_IDLE) || w_presc_clr) begin
      w_presc_nxt = '0;
    end else begin
      w_presc_nxt = r_presc;
    end
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_tick      <= 1'b0;
      r_cnt_clr   <= 1'b0;
      r_lap_latch <= 1'b0;
      r_hold      <= 1'b0;
      r_ovf       <= 1'b0;
      r_ss_d      <= 1'b1;
      r_lr_d      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_tick      <= w_tick_nxt;
      r_cnt_clr   <= w_cnt_clr_nxt;
      r_lap_latch <= w_lap_nxt;
      r_hold      <= w_hold_nxt;
      r_ovf       <= w_ovf_nxt;
      r_ss_d      <= i_btn_ss;
      r_lr_d      <= i_btn_lr;
    end
  end

  assign o_tick         = r_tick;
  assign o_cnt_clr      = r_cnt_clr;
  assign o_lap_latch    = r_lap_latch;
  assign o_display_hold = r_hold;
  assign o_ovf_flag     = r_ovf;
  assign o_state        = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl (DIV=4).
// The stimulus process drives buttons at negedges and pushes the expected
// responses (pulse cycle numbers and level snapshots) into queues; the monitor
// pops and compares whenever a pulse appears or a level snapshot falls due.
// Cycle number = count of posedges so far, read at the following negedge.

module tb_stopwatch_ctrl;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ss;
  logic       btn_lr;
  logic       ovf_in;
  logic       tick;
  logic       cnt_clr;
  logic       lap_latch;
  logic       display_hold;
  logic       ovf_flag;
  logic [1:0] state;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       hold;
    logic       ovf;
  } lvl_t;

  lvl_t q_lvl[$];
  int   q_tick[$];
  int   q_clr[$];
  int   q_lap[$];

  int   cyc      = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  logic done     = 1'b0;
  int   mon_exp;
  lvl_t mon_lvl;

  stopwatch_ctrl #(.DIV(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_btn_ss       (btn_ss),
    .i_btn_lr       (btn_lr),
    .i_ovf_in       (ovf_in),
    .o_tick         (tick),
    .o_cnt_clr      (cnt_clr),
    .o_lap_latch    (lap_latch),
    .o_display_hold (display_hold),
    .o_ovf_flag     (ovf_flag),
    .o_state        (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus helpers ----------------
  task automatic go(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic ss, input logic lr, input logic ov);
    rst    = r;
    btn_ss = ss;
    btn_lr = lr;
    ovf_in = ov;
  endtask

  task automatic exp_lvl(input int c, input logic [1:0] st, input logic h, input logic o);
    lvl_t e;
    e.cyc  = c;
    e.st   = st;
    e.hold = h;
    e.ovf  = o;
    q_lvl.push_back(e);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic cmp(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (tick === 1'b1) begin
      if (q_tick.size() != 0) mon_exp = q_tick.pop_front();
      else mon_exp = -1;
      cmp("tick_cycle", cyc, mon_exp);
    end
    if (cnt_clr === 1'b1) begin
      if (q_clr.size() != 0) mon_exp = q_clr.pop_front();
      else mon_exp = -1;
      cmp("cnt_clr_cycle", cyc, mon_exp);
    end
    if (lap_latch === 1'b1) begin
      if (q_lap.size() != 0) mon_exp = q_lap.pop_front();
      else mon_exp = -1;
      cmp("lap_latch_cycle", cyc, mon_exp);
    end
    while ((q_lvl.size() != 0) && (q_lvl[0].cyc <= cyc)) begin
      mon_lvl = q_lvl.pop_front();
      n_tests++;
      if ({state, display_hold, ovf_flag} !== {mon_lvl.st, mon_lvl.hold, mon_lvl.ovf}) begin
        n_fail++;
        $display("FAIL level@cyc%0d: got state=%0d hold=%0b ovf=%0b, expected state=%0d hold=%0b ovf=%0b",
                 cyc, state, display_hold, ovf_flag, mon_lvl.st, mon_lvl.hold, mon_lvl.ovf);
      end
    end
    if (done) begin
      cmp("tick_left", q_tick.size(), 0);
      cmp("cnt_clr_left", q_clr.size(), 0);
      cmp("lap_latch_left", q_lap.size(), 0);
      cmp("level_left", q_lvl.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    // 1. reset with start/stop held; no start until released and re-pressed
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_lvl(2, ST_IDLE, 1'b0, 1'b0);
    go(2);  drive(1'b0, 1'b1, 1'b0, 1'b0); exp_lvl(4, ST_IDLE, 1'b0, 1'b0);
    go(4);  drive(1'b0, 1'b0, 1'b0, 1'b0); exp_lvl(5, ST_IDLE, 1'b0, 1'b0);
    go(5);  drive(1'b0, 1'b1, 1'b0, 1'b0); exp_lvl(6, ST_RUN, 1'b0, 1'b0);
            exp_lvl(12, ST_RUN, 1'b0, 1'b0);
            q_tick.push_back(10); q_tick.push_back(14); q_tick.push_back(18);
    go(6);  drive(1'b0, 1'b0, 1'b0, 1'b0);

    // 2. pause with prescaler=2 (advances to 3 on the pausing edge), resume
    go(20); drive(1'b0, 1'b1, 1'b0, 1'b0); exp_lvl(21, ST_PAUSE, 1'b0, 1'b0);
            exp_lvl(30, ST_PAUSE, 1'b0, 1'b0);
    go(21); drive(1'b0, 1'b0, 1'b0, 1'b0);
    go(31); drive(1'b0, 1'b1, 1'b0, 1'b0); exp_lvl(32, ST_RUN, 1'b0, 1'b0);
            q_tick.push_back(33); q_tick.push_back(37); q_tick.push_back(41);
    go(32); drive(1'b0, 1'b0, 1'b0, 1'b0);

    // 3. two laps 6 cycles apart; ticks continue every 4 cycles
    go(34); drive(1'b0, 1'b0, 1'b1, 1'b0); exp_lvl(35, ST_LAP, 1'b1, 1'b0);
            q_lap.push_back(35); exp_lvl(38, ST_LAP, 1'b1, 1'b0);
    go(35); drive(1'b0, 1'b0, 1'b0, 1'b0);
    go(40); drive(1'b0, 1'b0, 1'b1, 1'b0); exp_lvl(41, ST_LAP, 1'b1, 1'b0);
            q_lap.push_back(41);
    go(41); drive(1'b0, 1'b0, 1'b0, 1'b0); exp_lvl(44, ST_LAP, 1'b1, 1'b0);
    // stop from LAP on the wrap edge: tick still appears in the PAUSE cycle
    go(44); drive(1'b0, 1'b1, 1'b0, 1'b0); exp_lvl(45, ST_PAUSE, 1'b0, 1'b0);
            q_tick.push_back(45);
    go(45); drive(1'b0, 1'b0, 1'b0, 1'b0);

    // 5. ss and lr together in RUN -> PAUSE only
    go(47); drive(1'b0, 1'b1, 1'b0, 1'b0); exp_lvl(48, ST_RUN, 1'b0, 1'b0);
    go(48); drive(1'b0, 1'b0, 1'b0, 1'b0);
    go(49); drive(1'b0, 1'b1, 1'b1, 1'b0); exp_lvl(50, ST_PAUSE, 1'b0, 1'b0);
    go(50); drive(1'b0, 1'b0, 1'b0, 1'b0);

    // 4. ovf_in with ss in RUN -> PAUSE + flag; ovf ignored in PAUSE; lr clears
    go(52); drive(1'b0, 1'b1, 1'b0, 1'b0); exp_lvl(53, ST_RUN, 1'b0, 1'b0);
            q_tick.push_back(55);
    go(53); drive(1'b0, 1'b0, 1'b0, 1'b0);
    go(54); drive(1'b0, 1'b1, 1'b0, 1'b1); exp_lvl(55, ST_PAUSE, 1'b0, 1'b1);
    go(55); drive(1'b0, 1'b0, 1'b0, 1'b0);
    go(56); drive(1'b0, 1'b0, 1'b0, 1'b1); exp_lvl(57, ST_PAUSE, 1'b0, 1'b1);
    go(57); drive(1'b0, 1'b0, 1'b0, 1'b0);
    go(58); drive(1'b0, 1'b0, 1'b1, 1'b0); exp_lvl(59, ST_IDLE, 1'b0, 1'b0);
            q_clr.push_back(59);
    go(59); drive(1'b0, 1'b0, 1'b0, 1'b0);
    // lr in IDLE pulses clear; ovf in IDLE ignored
    go(61); drive(1'b0, 1'b0, 1'b1, 1'b0); exp_lvl(62, ST_IDLE, 1'b0, 1'b0);
            q_clr.push_back(62);
    go(62); drive(1'b0, 1'b0, 1'b0, 1'b0);
    go(63); drive(1'b0, 1'b0, 1'b0, 1'b1); exp_lvl(64, ST_IDLE, 1'b0, 1'b0);
    go(64); drive(1'b0, 1'b0, 1'b0, 1'b0);

    // 6. reset in LAP with prescaler=3: no tick, no clear, everything idle
    go(65); drive(1'b0, 1'b1, 1'b0, 1'b0); exp_lvl(66, ST_RUN, 1'b0, 1'b0);
    go(66); drive(1'b0, 1'b0, 1'b0, 1'b0);
    go(67); drive(1'b0, 1'b0, 1'b1, 1'b0); exp_lvl(68, ST_LAP, 1'b1, 1'b0);
            q_lap.push_back(68); exp_lvl(69, ST_LAP, 1'b1, 1'b0);
    go(68); drive(1'b0, 1'b0, 1'b0, 1'b0);
    go(69); drive(1'b1, 1'b0, 1'b0, 1'b0); exp_lvl(70, ST_IDLE, 1'b0, 1'b0);
            exp_lvl(71, ST_IDLE, 1'b0, 1'b0);
    go(70); drive(1'b0, 1'b0, 1'b0, 1'b0);

    // restart after reset (prescaler cleared), lap, then overflow in LAP
    go(72); drive(1'b0, 1'b1, 1'b0, 1'b0); exp_lvl(73, ST_RUN, 1'b0, 1'b0);
            q_tick.push_back(77);
    go(73); drive(1'b0, 1'b0, 1'b0, 1'b0);
    go(74); drive(1'b0, 1'b0, 1'b1, 1'b0); exp_lvl(75, ST_LAP, 1'b1, 1'b0);
            q_lap.push_back(75);
    go(75); drive(1'b0, 1'b0, 1'b0, 1'b0);
    go(76); drive(1'b0, 1'b0, 1'b0, 1'b1); exp_lvl(77, ST_PAUSE, 1'b0, 1'b1);
    go(77); drive(1'b0, 1'b0, 1'b0, 1'b0);

    go(82);
    done = 1'b1;
  end

endmodule
